// File: rtl/pat_gen_engine.sv
// pat_gen_engine: plays a bit pattern stored in a byte-wide RAM onto up to
// eight GPIO lines at a programmable step rate.
//
// Ports:
//   clk, rst_n_sync      clock, asynchronous active-low reset
//   enable               run request (rising edge starts a run)
//   repeat_enable        loop back to byte 0 after end_address (live)
//   stage1_count_sel     prescaler select, step = (sel+1) * 2^timestep
//   num_gpio_sel         output width 1/2/4/8 bits
//   timestep_sel         step multiplier exponent, clamped to 15
//   end_address          last pattern byte address
//   ram_rd_en, ram_addr  pattern RAM read request
//   ram_rd_data          RAM data, valid one cycle after ram_rd_en
//   gpio_out             current pattern sample, unused upper bits zero
//   active, done         status: FETCH/RUN, DONE
//
// Optional feature: define PAT_GEN_TRIG_EN to add trig_in; a run then starts
// on enable=1 plus a trig_in rising edge, and every repeat wrap waits (holding
// the last sample) for another trig_in rising edge.
module pat_gen_engine #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n_sync,
    input  logic              enable,
    input  logic              repeat_enable,
    input  logic [3:0]        stage1_count_sel,
    input  logic [1:0]        num_gpio_sel,
    input  logic [4:0]        timestep_sel,
    input  logic [ADDR_W-1:0] end_address,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_rd_data,
    output logic [7:0]        gpio_out,
    output logic              active,
`ifdef PAT_GEN_TRIG_EN
    input  logic              trig_in,
`endif
    output logic              done
);

    localparam int unsigned CNT_W = 20;

    typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_t;

    state_t            state;
    logic              en_prev;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] end_q;
    logic [1:0]        gsel_q;
    logic [4:0]        ts_q;
    logic [3:0]        s1_q;
    logic [ADDR_W-1:0] byte_addr;
    logic [7:0]        shift_q;
    logic [3:0]        left_q;
    logic [7:0]        buf_q;
    logic              buf_vld;
    logic [CNT_W-1:0]  step_cnt;
`ifdef PAT_GEN_TRIG_EN
    logic              trig_prev;
`endif

    logic [3:0]        ts_eff;
    logic [CNT_W-1:0]  period_raw;
    logic [CNT_W-1:0]  period;
    logic [3:0]        w_bits;
    logic [7:0]        mask;
    logic [3:0]        spb;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] next2_addr;
    logic [7:0]        new_byte;
    logic              at_end;
    logic              start_go;
    logic              wrap_go;

    // Step period, sample geometry and address sequencing from latched config
    always_comb begin
        ts_eff     = (ts_q > 5'd15) ? 4'd15 : ts_q[3:0];
        period_raw = (CNT_W'(s1_q) + CNT_W'(1)) << ts_eff;
        period     = (period_raw < CNT_W'(2)) ? CNT_W'(2) : period_raw;
        w_bits     = 4'd1 << gsel_q;
        mask       = 8'((9'd1 << w_bits) - 9'd1);
        spb        = 4'd8 >> gsel_q;
        at_end     = (byte_addr == end_q);
        next_addr  = at_end ? '0 : byte_addr + ADDR_W'(1);
        next2_addr = (next_addr == end_q) ? '0 : next_addr + ADDR_W'(1);
        // The prefetched byte may still be on the RAM bus when it is needed
        new_byte   = buf_vld ? buf_q : ram_rd_data;
`ifdef PAT_GEN_TRIG_EN
        start_go   = enable & trig_in & ~trig_prev;
        wrap_go    = trig_in & ~trig_prev;
`else
        start_go   = enable & ~en_prev;
        wrap_go    = 1'b1;
`endif
    end

    // Sequencer: state, RAM requests, prefetch buffer and sample output
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state     <= IDLE;
            // Reset as "high" so an enable held through reset is not an edge
            en_prev   <= 1'b1;
            rd_vld_q  <= 1'b0;
            end_q     <= '0;
            gsel_q    <= '0;
            ts_q      <= '0;
            s1_q      <= '0;
            byte_addr <= '0;
            shift_q   <= '0;
            left_q    <= '0;
            buf_q     <= '0;
            buf_vld   <= 1'b0;
            step_cnt  <= '0;
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
            gpio_out  <= '0;
            active    <= 1'b0;
            done      <= 1'b0;
`ifdef PAT_GEN_TRIG_EN
            trig_prev <= 1'b0;
`endif
        end else begin
            en_prev   <= enable;
            rd_vld_q  <= ram_rd_en & enable;
            ram_rd_en <= 1'b0;
`ifdef PAT_GEN_TRIG_EN
            trig_prev <= trig_in;
`endif
            case (state)
                IDLE: begin
                    gpio_out <= '0;
                    done     <= 1'b0;
                    if (start_go) begin
                        state     <= FETCH;
                        end_q     <= end_address;
                        gsel_q    <= num_gpio_sel;
                        ts_q      <= timestep_sel;
                        s1_q      <= stage1_count_sel;
                        byte_addr <= '0;
                        buf_vld   <= 1'b0;
                        ram_rd_en <= 1'b1;
                        ram_addr  <= '0;
                        active    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!enable) begin
                        state    <= IDLE;
                        gpio_out <= '0;
                        active   <= 1'b0;
                        buf_vld  <= 1'b0;
                    end else if (rd_vld_q) begin
                        // First byte in hand; prefetch the next one right away
                        state     <= RUN;
                        shift_q   <= ram_rd_data;
                        left_q    <= spb;
                        byte_addr <= '0;
                        step_cnt  <= '0;
                        ram_rd_en <= 1'b1;
                        ram_addr  <= next_addr;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state    <= IDLE;
                        gpio_out <= '0;
                        active   <= 1'b0;
                        buf_vld  <= 1'b0;
                    end else begin
                        if (rd_vld_q) begin
                            buf_q   <= ram_rd_data;
                            buf_vld <= 1'b1;
                        end
                        if (step_cnt != '0) begin
                            step_cnt <= step_cnt - CNT_W'(1);
                        end else if (left_q != 4'd0) begin
                            gpio_out <= shift_q & mask;
                            shift_q  <= shift_q >> w_bits;
                            left_q   <= left_q - 4'd1;
                            step_cnt <= period - CNT_W'(1);
                        end else if (at_end && !repeat_enable) begin
                            state    <= DONE;
                            gpio_out <= '0;
                            active   <= 1'b0;
                            done     <= 1'b1;
                            buf_vld  <= 1'b0;
                        end else if (!at_end || wrap_go) begin
                            // Byte exhausted: play next byte, request the one after
                            gpio_out  <= new_byte & mask;
                            shift_q   <= new_byte >> w_bits;
                            left_q    <= spb - 4'd1;
                            byte_addr <= next_addr;
                            buf_vld   <= 1'b0;
                            ram_rd_en <= 1'b1;
                            ram_addr  <= next2_addr;
                            step_cnt  <= period - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    gpio_out <= '0;
                    if (!enable) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pat_gen_engine.md
PAT_GEN_ENGINE -- requirements
Module: pat_gen_engine

Interface
REQ-001 Parameter ADDR_W, default 13, width of the pattern RAM byte address.
REQ-002 clk  input  1  system clock; all logic is on the rising edge.
REQ-003 rst_n_sync  input  1  reset: asynchronous, active-low.
REQ-004 enable  input  1  run request from the register map (reg0[0]).
REQ-005 repeat_enable  input  1  loop pattern at end (reg0[1]).
REQ-006 stage1_count_sel  input  4  prescaler select (reg0[7:4]).
REQ-007 num_gpio_sel  input  2  output width select: 0=1 bit, 1=2 bits, 2=4 bits, 3=8 bits.
REQ-008 timestep_sel  input  5  step multiplier exponent; values above 15 are treated as 15.
REQ-009 end_address  input  ADDR_W  last RAM byte address of the pattern.
REQ-010 ram_rd_en  output  1  pattern RAM read strobe.
REQ-011 ram_addr  output  ADDR_W  pattern RAM read address.
REQ-012 ram_rd_data  input  8  RAM data, valid exactly 1 cycle after ram_rd_en.
REQ-013 gpio_out  output  8  pattern sample; bits above the selected width are driven 0.
REQ-014 active  output  1  high in the FETCH and RUN states.
REQ-015 done  output  1  high in the DONE state.

Function
REQ-016 FSM states: IDLE, FETCH, RUN, DONE.
REQ-017 IDLE->FETCH on an enable rising edge; latch end_address, num_gpio_sel, timestep_sel, stage1_count_sel at that edge; repeat_enable stays live.
REQ-018 FETCH: ram_rd_en=1, ram_addr=0 for 1 cycle; next cycle capture ram_rd_data into the shift register and the byte address counter=0; enter RUN.
REQ-019 First sample drives gpio_out from the 3rd rising edge after the edge that samples enable=1.
REQ-020 Step period (clk cycles) = max(2, (stage1_count_sel+1) * 2^min(timestep_sel,15)); gpio_out changes only on step boundaries.
REQ-021 Samples per byte = 8 >> num_gpio_sel, taken LSB-first: sample k = byte[(k+1)*W-1 : k*W], where W = 1 << num_gpio_sel.
REQ-022 Prefetch buffer: the read of the next byte (address+1, or 0 on wrap) is issued in the cycle after the current byte is loaded; output has no gap between bytes.
REQ-023 After the last sample of byte end_address: if repeat_enable=1, continue with byte 0 with no gap; else go to DONE.
REQ-024 DONE: gpio_out=0, done=1; DONE->IDLE when enable=0.
REQ-025 enable=0 in FETCH or RUN: return to IDLE on the next edge, gpio_out=0, and drop any pending read data.
REQ-026 end_address=0: the single byte is played, and repeated if repeat_enable=1.
REQ-027 The byte address counter is ADDR_W wide and never exceeds end_address.
REQ-028 ram_rd_en is never asserted in IDLE or DONE.

Reset
REQ-029 Reset asserted: state=IDLE; gpio_out, ram_rd_en, ram_addr, active, done, counters and latched config all =0.
REQ-030 Reset asserted mid-run aborts immediately; after release, a new enable rising edge is required to start.

Configuration
REQ-031 Macro PAT_GEN_TRIG_EN: when defined, input trig_in (1 bit, synchronous to clk) is added; IDLE->FETCH requires enable=1 and a trig_in rising edge; each repeat wrap also waits in RUN, holding the last sample, for a new trig_in rising edge.
REQ-032 Without PAT_GEN_TRIG_EN: trig_in is absent and the block starts on the enable rising edge alone.

Verification
REQ-033 num_gpio_sel=3, stage1=0, timestep=0, end_address=3, RAM={11,22,33,44}: gpio_out sequence 11,22,33,44, each held 2 cycles; then done=1 and gpio_out=0.
REQ-034 num_gpio_sel=0, stage1=1, timestep=1, end_address=0, byte=A5: gpio_out[0] sequence 1,0,1,0,0,1,0,1, each held 4 cycles.
REQ-035 repeat_enable=1, num_gpio_sel=2, end_address=1, RAM={21,43}: gpio_out[3:0] cycles 1,2,3,4,1,2... with no gap; clearing repeat_enable ends the run after the next 4.
REQ-036 enable dropped mid-byte: IDLE and gpio_out=0 one edge later; ram_rd_en stays 0 afterwards.
REQ-037 timestep_sel=20, stage1=0: step period measured as 32768 cycles.
REQ-038 rst_n_sync pulsed during RUN: all outputs 0 immediately; enable held high does not restart the run until it toggles.
